// File: rtl/pov_spi_master_pkg.sv
// Shared types and sizing helpers for the POV view-vector SPI transmitter.
package pov_spi_master_pkg;

    // Default vector width: Qm + Qn of the POV fixed-point format.
    localparam int unsigned FW_DEFAULT = 24;
    localparam int unsigned N_VEC      = 6;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LEAD     = 3'd1,
        ST_SHIFT_HI = 3'd2,
        ST_SHIFT_LO = 3'd3,
        ST_TRAIL    = 3'd4,
        ST_GAP      = 3'd5
    } state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pov_spi_master.sv
// Serialises one playerX..vplaneY view-vector frame onto a mode-0 SPI link
// (MSB first) per accepted start request.
module pov_spi_master
    import pov_spi_master_pkg::*;
#(
    parameter int unsigned FW      = FW_DEFAULT,
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned SS_GAP  = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_start,
    input  logic [FW-1:0] i_playerX,
    input  logic [FW-1:0] i_playerY,
    input  logic [FW-1:0] i_facingX,
    input  logic [FW-1:0] i_facingY,
    input  logic [FW-1:0] i_vplaneX,
    input  logic [FW-1:0] i_vplaneY,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_sclk,
    output logic          o_mosi,
    output logic          o_ss_n
);

    localparam int unsigned NBITS = N_VEC * FW;
    // Divider also times the SS gap, so it must hold both reload values.
    localparam int unsigned DIV_W = max_u(1, max_u($clog2(CLK_DIV), $clog2(SS_GAP)));
    localparam int unsigned BIT_W = $clog2(NBITS);

    state_e             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [NBITS-1:0]   sh_q, sh_d;
    logic               ss_n_q, ss_n_d;
    logic               sclk_q, sclk_d;
    logic               mosi_q, mosi_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               div_last;

    assign div_last = (div_q == '0);

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            ss_n_q  <= 1'b1;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            ss_n_q  <= ss_n_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        div_d   = div_last ? div_q : div_q - DIV_W'(1);
        bit_d   = bit_q;
        sh_d    = sh_q;
        ss_n_d  = ss_n_q;
        sclk_d  = sclk_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    sh_d    = {i_playerX, i_playerY, i_facingX, i_facingY, i_vplaneX, i_vplaneY};
                    state_d = ST_LEAD;
                    div_d   = DIV_W'(CLK_DIV - 1);
                    bit_d   = '0;
                    ss_n_d  = 1'b0;
                    sclk_d  = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            ST_LEAD: begin
                if (div_last) begin
                    state_d = ST_SHIFT_HI;
                    div_d   = DIV_W'(CLK_DIV - 1);
                    sclk_d  = 1'b1;
                end
            end
            ST_SHIFT_HI: begin
                // Shifting on the falling edge refills with zeros, so MOSI is 0 after the last bit.
                if (div_last) begin
                    state_d = ST_SHIFT_LO;
                    div_d   = DIV_W'(CLK_DIV - 1);
                    sclk_d  = 1'b0;
                    sh_d    = {sh_q[NBITS-2:0], 1'b0};
                end
            end
            ST_SHIFT_LO: begin
                if (div_last) begin
                    div_d = DIV_W'(CLK_DIV - 1);
                    if (bit_q == BIT_W'(NBITS - 1)) begin
                        state_d = ST_TRAIL;
                    end else begin
                        state_d = ST_SHIFT_HI;
                        bit_d   = bit_q + BIT_W'(1);
                        sclk_d  = 1'b1;
                    end
                end
            end
            ST_TRAIL: begin
                if (div_last) begin
                    state_d = ST_GAP;
                    div_d   = DIV_W'(SS_GAP - 1);
                    ss_n_d  = 1'b1;
                    done_d  = 1'b1;
                end
            end
            ST_GAP: begin
                if (div_last) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ss_n_d  = 1'b1;
                sclk_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase

        mosi_d = sh_d[NBITS-1];
    end

    assign o_busy = busy_q;
    assign o_done = done_q;
    assign o_sclk = sclk_q;
    assign o_mosi = mosi_q;
    assign o_ss_n = ss_n_q;

endmodule
